// File: rtl/ysyx_22050854_axi_line_master_if.sv
// AXI4 channel bundle between ysyx_22050854_axi_line_master and the SoC port.
// master: the line master (drives AR/AW/W valids, R/B readies).
// slave:  the memory-side model or interconnect.
interface ysyx_22050854_axi_line_master_if;
  // AR channel
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  // R channel
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;
  // AW channel
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  // W channel
  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  // B channel
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );
endinterface

// File: rtl/ysyx_22050854_axi_line_master.sv
// AXI4 line master: converts one cache-side request at a time into a
// 2-beat INCR burst (128-bit line) or a single-beat FIXED transfer (device).
// Optional watchdog: define AXI_LINE_MASTER_TIMEOUT_EN to abort a stuck
// transaction after TIMEOUT_CYCLES cycles without a handshake.
module ysyx_22050854_axi_line_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                            clock,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic                            req_line,
  input  logic [31:0]                     req_addr,
  input  logic [3:0]                      req_id,
  input  logic [127:0]                    req_wdata,
  input  logic [7:0]                      req_wstrb,
  output logic                            resp_valid,
  output logic [127:0]                    resp_rdata,
  output logic                            resp_err,
  ysyx_22050854_axi_line_master_if.master axi
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_RESP
  } state_t;

  state_t state_q, state_d;

  // Latched request context
  logic         line_q,  line_d;
  logic [127:0] wbuf_q,  wbuf_d;
  logic [7:0]   wmask_q, wmask_d;
  logic [127:0] rbuf_q,  rbuf_d;
  logic         err_q,   err_d;
  logic         beat_q,  beat_d;

  // Registered AXI outputs
  logic        arvalid_q, arvalid_d;
  logic [31:0] araddr_q,  araddr_d;
  logic [3:0]  arid_q,    arid_d;
  logic [7:0]  arlen_q,   arlen_d;
  logic [2:0]  arsize_q,  arsize_d;
  logic [1:0]  arburst_q, arburst_d;
  logic        rready_q,  rready_d;
  logic        awvalid_q, awvalid_d;
  logic [31:0] awaddr_q,  awaddr_d;
  logic [3:0]  awid_q,    awid_d;
  logic [7:0]  awlen_q,   awlen_d;
  logic [2:0]  awsize_q,  awsize_d;
  logic [1:0]  awburst_q, awburst_d;
  logic        wvalid_q,  wvalid_d;
  logic [63:0] wdata_q,   wdata_d;
  logic [7:0]  wstrb_q,   wstrb_d;
  logic        wlast_q,   wlast_d;
  logic        bready_q,  bready_d;

  // Registered response outputs
  logic         resp_valid_q, resp_valid_d;
  logic [127:0] resp_rdata_q, resp_rdata_d;
  logic         resp_err_q,   resp_err_d;

  // Request-derived burst shape
  logic [31:0] addr_sel;
  logic [7:0]  len_sel;
  logic [1:0]  burst_sel;
  logic        r_decerr;
  logic        b_decerr;

  assign addr_sel  = req_line ? {req_addr[31:4], 4'b0000} : req_addr;
  assign len_sel   = req_line ? 8'd1 : 8'd0;
  assign burst_sel = req_line ? 2'b01 : 2'b00;
  assign r_decerr  = (axi.rresp == 2'b11);
  assign b_decerr  = (axi.bresp == 2'b11);

  assign req_ready = (state_q == ST_IDLE);

`ifdef AXI_LINE_MASTER_TIMEOUT_EN
  localparam logic [15:0] WDT_LIMIT = 16'(TIMEOUT_CYCLES - 32'd1);

  logic [15:0] wdt_q, wdt_d;
  logic        hs;
  logic        busy;

  assign hs = (arvalid_q & axi.arready) | (rready_q  & axi.rvalid) |
              (awvalid_q & axi.awready) | (wvalid_q  & axi.wready) |
              (bready_q  & axi.bvalid);
  assign busy = (state_q == ST_AR) || (state_q == ST_R) || (state_q == ST_AW) ||
                (state_q == ST_W)  || (state_q == ST_B);
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 32'd0);
`endif

  logic unused_axi;
  assign unused_axi = ^{axi.rlast, axi.rid, axi.bid};

  // Next-state, next-output and datapath update for the transaction FSM
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    wbuf_d       = wbuf_q;
    wmask_d      = wmask_q;
    rbuf_d       = rbuf_q;
    err_d        = err_q;
    beat_d       = beat_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arid_d       = arid_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    awaddr_d     = awaddr_q;
    awid_d       = awid_q;
    awlen_d      = awlen_q;
    awsize_d     = awsize_q;
    awburst_d    = awburst_q;
    wvalid_d     = wvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wlast_d      = wlast_q;
    bready_d     = bready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          line_d  = req_line;
          wbuf_d  = req_wdata;
          wmask_d = req_wstrb;
          rbuf_d  = '0;
          err_d   = 1'b0;
          beat_d  = 1'b0;
          if (req_write) begin
            state_d   = ST_AW;
            awvalid_d = 1'b1;
            awaddr_d  = addr_sel;
            awid_d    = req_id;
            awlen_d   = len_sel;
            awsize_d  = 3'd3;
            awburst_d = burst_sel;
          end else begin
            state_d   = ST_AR;
            arvalid_d = 1'b1;
            araddr_d  = addr_sel;
            arid_d    = req_id;
            arlen_d   = len_sel;
            arsize_d  = 3'd3;
            arburst_d = burst_sel;
          end
        end
      end

      ST_AR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end
      end

      ST_R: begin
        if (axi.rvalid && rready_q) begin
          rbuf_d = beat_q ? {axi.rdata, rbuf_q[63:0]} : {rbuf_q[127:64], axi.rdata};
          err_d  = err_q | r_decerr;
          // Completion is counted by beats, not by rlast
          if (!line_q || beat_q) begin
            rready_d     = 1'b0;
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = rbuf_d;
            resp_err_d   = err_d;
          end else begin
            beat_d = 1'b1;
          end
        end
      end

      ST_AW: begin
        if (axi.awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wdata_d   = wbuf_q[63:0];
          wstrb_d   = line_q ? 8'hff : wmask_q;
          wlast_d   = !line_q;
          state_d   = ST_W;
        end
      end

      ST_W: begin
        if (axi.wready) begin
          if (wlast_q) begin
            wvalid_d = 1'b0;
            bready_d = 1'b1;
            state_d  = ST_B;
          end else begin
            wdata_d = wbuf_q[127:64];
            wlast_d = 1'b1;
          end
        end
      end

      ST_B: begin
        if (axi.bvalid) begin
          bready_d     = 1'b0;
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = err_q | b_decerr;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef AXI_LINE_MASTER_TIMEOUT_EN
    // Watchdog overrides the FSM; counter is zero outside busy states
    wdt_d = '0;
    if (busy && !hs) begin
      if (wdt_q == WDT_LIMIT) begin
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        awvalid_d    = 1'b0;
        wvalid_d     = 1'b0;
        bready_d     = 1'b0;
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 1'b1;
      end else begin
        wdt_d = wdt_q + 16'd1;
      end
    end
`endif
  end

  // State, context and registered outputs
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      line_q       <= 1'b0;
      wbuf_q       <= '0;
      wmask_q      <= '0;
      rbuf_q       <= '0;
      err_q        <= 1'b0;
      beat_q       <= 1'b0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arid_q       <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      awid_q       <= '0;
      awlen_q      <= '0;
      awsize_q     <= '0;
      awburst_q    <= '0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      wbuf_q       <= wbuf_d;
      wmask_q      <= wmask_d;
      rbuf_q       <= rbuf_d;
      err_q        <= err_d;
      beat_q       <= beat_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arid_q       <= arid_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      awaddr_q     <= awaddr_d;
      awid_q       <= awid_d;
      awlen_q      <= awlen_d;
      awsize_q     <= awsize_d;
      awburst_q    <= awburst_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wlast_q      <= wlast_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef AXI_LINE_MASTER_TIMEOUT_EN
  // Watchdog counter register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`endif

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arid    = arid_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = arburst_q;
  assign axi.rready  = rready_q;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awid    = awid_q;
  assign axi.awlen   = awlen_q;
  assign axi.awsize  = awsize_q;
  assign axi.awburst = awburst_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = wlast_q;
  assign axi.bready  = bready_q;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_22050854_axi_line_master.sv
// Scoreboard bench for ysyx_22050854_axi_line_master: expected responses are
// queued when a request is driven and compared when resp_valid pulses.
// With AXI_LINE_MASTER_TIMEOUT_EN defined, the watchdog abort is exercised too.
module tb_ysyx_22050854_axi_line_master;

`ifdef AXI_LINE_MASTER_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 16;
`else
  localparam int unsigned TB_TIMEOUT = 1024;
`endif

  logic         clock;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic         req_line;
  logic [31:0]  req_addr;
  logic [3:0]   req_id;
  logic [127:0] req_wdata;
  logic [7:0]   req_wstrb;
  logic         resp_valid;
  logic [127:0] resp_rdata;
  logic         resp_err;

  ysyx_22050854_axi_line_master_if axi ();

  ysyx_22050854_axi_line_master #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_line   (req_line),
    .req_addr   (req_addr),
    .req_id     (req_id),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi        (axi)
  );

  typedef struct packed {
    logic [127:0] rdata;
    logic         err;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned cyc;
  int unsigned acc_cyc;
  int unsigned last_resp_cyc;
  int unsigned w_beats;
  logic        prev_rv;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Response scoreboard and W beat counter, sampled mid-cycle
  always @(negedge clock) begin
    if (!rst_n) begin
      prev_rv = 1'b0;
    end else begin
      if (axi.wvalid && axi.wready) w_beats++;
      if (resp_valid) begin
        check("resp_pulse_width", prev_rv, 1'b0);
        last_resp_cyc = cyc;
        if (sb_q.size() == 0) begin
          check("resp_unexpected", resp_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", resp_err, e.err);
        end
      end
      prev_rv = resp_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic wr, input logic line, input logic [31:0] addr,
                        input logic [3:0] id, input logic [127:0] wd, input logic [7:0] ws);
    req_write = wr;
    req_line  = line;
    req_addr  = addr;
    req_id    = id;
    req_wdata = wd;
    req_wstrb = ws;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) tick();
    check("req_ready", req_ready, 1'b1);
    acc_cyc = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic serve_ar(input int delay, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] id);
    for (int i = 0; i < 50 && !axi.arvalid; i++) tick();
    check("arvalid", axi.arvalid, 1'b1);
    check("araddr", axi.araddr, addr);
    check("arlen", axi.arlen, len);
    check("arburst", axi.arburst, burst);
    check("arid", axi.arid, id);
    check("arsize", axi.arsize, 3'd3);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, addr});
    end
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    check("ar_drop", axi.arvalid, 1'b0);
  endtask

  task automatic serve_r(input int n, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [1:0] rr0, input logic [1:0] rr1);
    for (int i = 0; i < 50 && !axi.rready; i++) tick();
    check("rready", axi.rready, 1'b1);
    axi.rvalid = 1'b1;
    axi.rdata  = d0;
    axi.rresp  = rr0;
    axi.rlast  = (n == 1);
    tick();
    if (n == 2) begin
      axi.rdata = d1;
      axi.rresp = rr1;
      axi.rlast = 1'b1;
      tick();
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
  endtask

  task automatic serve_aw(input int delay, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] id);
    for (int i = 0; i < 50 && !axi.awvalid; i++) tick();
    check("awvalid", axi.awvalid, 1'b1);
    check("awaddr", axi.awaddr, addr);
    check("awlen", axi.awlen, len);
    check("awburst", axi.awburst, burst);
    check("awid", axi.awid, id);
    check("w_before_aw", axi.wvalid, 1'b0);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("aw_hold", axi.awvalid, 1'b1);
      check("w_before_aw", axi.wvalid, 1'b0);
    end
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
  endtask

  task automatic serve_w(input int n, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [7:0] strb, input int stall1);
    for (int b = 0; b < n; b++) begin
      logic [63:0] ed;
      logic        el;
      ed = (b == 0) ? d0 : d1;
      el = (b == n - 1);
      for (int i = 0; i < 50 && !axi.wvalid; i++) tick();
      check("wvalid", axi.wvalid, 1'b1);
      check("wdata", axi.wdata, ed);
      check("wlast", axi.wlast, el);
      check("wstrb", axi.wstrb, strb);
      if (b == 1) begin
        for (int i = 0; i < stall1; i++) begin
          tick();
          check("w_stall_stable", {axi.wvalid, axi.wlast, axi.wdata}, {1'b1, el, ed});
        end
      end
      axi.wready = 1'b1;
      tick();
      axi.wready = 1'b0;
    end
    check("w_drop", axi.wvalid, 1'b0);
  endtask

  task automatic serve_b(input logic [1:0] resp);
    for (int i = 0; i < 50 && !axi.bready; i++) tick();
    check("bready", axi.bready, 1'b1);
    axi.bvalid = 1'b1;
    axi.bresp  = resp;
    tick();
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && !req_ready; i++) tick();
    check("back_to_idle", req_ready, 1'b1);
  endtask

  function automatic exp_t mk(input logic [127:0] d, input logic e);
    exp_t x;
    x.rdata = d;
    x.err   = e;
    return x;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valids"}, {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid,
                             axi.bready, resp_valid, resp_err}, 7'd0);
    check({tag, "_addr"}, {axi.araddr, axi.awaddr, axi.arid, axi.awid, axi.arlen, axi.awlen}, '0);
    check({tag, "_data"}, {axi.wdata, axi.wstrb, axi.wlast}, '0);
    check({tag, "_rdata"}, resp_rdata, '0);
    check({tag, "_req_ready"}, req_ready, 1'b1);
  endtask

  initial begin
    int unsigned wb0;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    w_beats = 0;
    prev_rv = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_line = 1'b0;
    req_addr = '0;
    req_id = '0;
    req_wdata = '0;
    req_wstrb = '0;
    axi.arready = 1'b0;
    axi.rvalid = 1'b0;
    axi.rdata = '0;
    axi.rresp = '0;
    axi.rid = '0;
    axi.rlast = 1'b0;
    axi.awready = 1'b0;
    axi.wready = 1'b0;
    axi.bvalid = 1'b0;
    axi.bresp = '0;
    axi.bid = '0;
    rst_n = 1'b0;

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check("post_reset_req_ready", req_ready, 1'b1);

    // Line read, zero-wait slave
    sb_q.push_back(mk({64'h22, 64'h11}, 1'b0));
    do_req(1'b0, 1'b1, 32'h8000_0014, 4'd3, '0, 8'h00);
    serve_ar(0, 32'h8000_0010, 8'd1, 2'b01, 4'd3);
    serve_r(2, 64'h11, 64'h22, 2'b00, 2'b00);
    wait_idle();
    check("line_read_latency", last_resp_cyc - acc_cyc, 4);

    // Single write, zero-wait slave
    sb_q.push_back(mk('0, 1'b0));
    do_req(1'b1, 1'b0, 32'hA000_03F8, 4'd5, 128'h55, 8'h0F);
    serve_aw(0, 32'hA000_03F8, 8'd0, 2'b00, 4'd5);
    serve_w(1, 64'h55, 64'h0, 8'h0F, 0);
    serve_b(2'b00);
    wait_idle();
    check("single_write_latency", last_resp_cyc - acc_cyc, 4);

    // Line write with AW delay and a stalled second beat
    wb0 = w_beats;
    sb_q.push_back(mk('0, 1'b0));
    do_req(1'b1, 1'b1, 32'h8000_1238, 4'd9,
           {64'hCAFE_F00D_1234_5678, 64'hDEAD_BEEF_0BAD_F00D}, 8'h01);
    serve_aw(3, 32'h8000_1230, 8'd1, 2'b01, 4'd9);
    serve_w(2, 64'hDEAD_BEEF_0BAD_F00D, 64'hCAFE_F00D_1234_5678, 8'hff, 2);
    serve_b(2'b01);
    wait_idle();
    check("line_write_beats", w_beats - wb0, 2);

    // DECERR on B, then SLVERR on a single read is not flagged
    sb_q.push_back(mk('0, 1'b1));
    do_req(1'b1, 1'b0, 32'h1000_0000, 4'd1, 128'hAA, 8'hFF);
    serve_aw(0, 32'h1000_0000, 8'd0, 2'b00, 4'd1);
    serve_w(1, 64'hAA, 64'h0, 8'hFF, 0);
    serve_b(2'b11);
    wait_idle();
    sb_q.push_back(mk({64'h0, 64'h77}, 1'b0));
    do_req(1'b0, 1'b0, 32'h1000_0008, 4'd2, '0, 8'h00);
    serve_ar(0, 32'h1000_0008, 8'd0, 2'b00, 4'd2);
    serve_r(1, 64'h77, 64'h0, 2'b10, 2'b00);
    wait_idle();
    check("single_read_latency", last_resp_cyc - acc_cyc, 3);

    // DECERR on first beat only stays sticky through the burst
    sb_q.push_back(mk({64'hBBBB, 64'hAAAA}, 1'b1));
    do_req(1'b0, 1'b1, 32'h8000_0020, 4'd7, '0, 8'h00);
    serve_ar(1, 32'h8000_0020, 8'd1, 2'b01, 4'd7);
    serve_r(2, 64'hAAAA, 64'hBBBB, 2'b11, 2'b00);
    wait_idle();

    // Reset in the middle of a line read, after beat 0
    do_req(1'b0, 1'b1, 32'h8000_0040, 4'd4, '0, 8'h00);
    serve_ar(0, 32'h8000_0040, 8'd1, 2'b01, 4'd4);
    for (int i = 0; i < 50 && !axi.rready; i++) tick();
    axi.rvalid = 1'b1;
    axi.rdata = 64'h1234;
    tick();
    axi.rvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    sb_q.push_back(mk({64'h5678, 64'h9ABC}, 1'b0));
    do_req(1'b0, 1'b1, 32'h8000_0048, 4'd6, '0, 8'h00);
    serve_ar(0, 32'h8000_0040, 8'd1, 2'b01, 4'd6);
    serve_r(2, 64'h9ABC, 64'h5678, 2'b00, 2'b00);
    wait_idle();

`ifdef AXI_LINE_MASTER_TIMEOUT_EN
    // Watchdog abort with arready held low
    begin
      int unsigned hi_cnt;
      hi_cnt = 0;
      sb_q.push_back(mk('0, 1'b1));
      do_req(1'b0, 1'b1, 32'h8000_0100, 4'd8, '0, 8'h00);
      for (int i = 0; i < 100 && axi.arvalid; i++) begin
        hi_cnt++;
        tick();
      end
      check("wdt_arvalid_cycles", hi_cnt, 16);
      check("wdt_arvalid_drop", axi.arvalid, 1'b0);
      wait_idle();
    end
`endif

    tick();
    tick();
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
